axi_str_rx_pkt_fifo: RTL and testbench

- AXI-Stream slave (receiving end) that accepts beats from an upstream master and stores them in an internal buffer.
- Forwards data on an AXI-Stream master port only once a whole packet (through tlast) has been received, i.e. store-and-forward.
- Sits between the MAC-side stream producer and the AXI consumer.
- Isolates the consumer from partial packets and discards packets that can never fit in the buffer.

---
 rtl/axi_str_rx_pkg.sv | 28 ++
 rtl/axi_str_rx_mem.sv | 28 ++
 rtl/axi_str_rx_pkt_fifo.sv | 141 ++++++++++++++
 tb/tb_axi_str_rx_pkt_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_str_rx_pkg.sv
// axi_str_rx_pkg: shared types and helpers for the store-and-forward RX FIFO.
// Beat layout in the buffer is {data, keep, last[, user]}, data at the MSBs.
package axi_str_rx_pkg;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_t;

    localparam int BEAT_DATA_W = 32;
    localparam int BEAT_USER_W = 32;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0]   data;
        logic [BEAT_DATA_W/8-1:0] keep;
        logic                     last;
        logic [BEAT_USER_W-1:0]   user;
    } beat_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axi_str_rx_mem.sv
// axi_str_rx_mem: single-clock beat buffer, one write port and an
// asynchronous read port so the FIFO head is visible in the same cycle.
module axi_str_rx_mem
    import axi_str_rx_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_str_rx_pkt_fifo.sv
// axi_str_rx_pkt_fifo: AXI-Stream store-and-forward packet FIFO that drops
// packets too large for the buffer. Define AXI_STR_RX_USER_EN to carry tuser.
module axi_str_rx_pkt_fifo
    import axi_str_rx_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int USER_SIZE = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [DATA_SIZE-1:0]     s_tdata,
    input  logic [DATA_SIZE/8-1:0]   s_tkeep,
    input  logic                     s_tlast,
    input  logic [USER_SIZE-1:0]     s_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [DATA_SIZE-1:0]     m_tdata,
    output logic [DATA_SIZE/8-1:0]   m_tkeep,
    output logic                     m_tlast,
    output logic [USER_SIZE-1:0]     m_tuser,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = addr_w(DEPTH);
    localparam int KW = DATA_SIZE / 8;
`ifdef AXI_STR_RX_USER_EN
    localparam int BW = DATA_SIZE + KW + 1 + USER_SIZE;
`else
    localparam int BW = DATA_SIZE + KW + 1;
`endif

    wr_state_t      state, state_nxt;
    logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0]  fill;
    logic           full;
    logic           overflow;
    logic           wr_en;
    logic           commit;
    logic           drop_last;
    logic           rd_fire;
    logic           rd_last;
    logic [BW-1:0]  wdata, rdata;

    assign fill = wr_ptr - rd_ptr;
    assign full = (fill == PW'(DEPTH));

    always_comb begin
        state_nxt = state;
        s_tready  = 1'b0;
        overflow  = 1'b0;
        unique case (state)
            ACCEPT: begin
                s_tready = !areset && !full;
                // Nothing left to drain means this packet can never fit.
                overflow = full && (pkt_count == '0)
                           && (wr_ptr != commit_ptr);
                if (overflow) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                s_tready = !areset;
                if (s_tvalid && s_tlast) begin
                    state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    assign wr_en     = (state == ACCEPT) && s_tvalid && s_tready;
    assign commit    = wr_en && s_tlast;
    assign drop_last = (state == DROP) && s_tvalid && s_tready && s_tlast;

    assign m_tvalid = !areset && (rd_ptr != commit_ptr);
    assign rd_fire  = m_tvalid && m_tready;
    assign rd_last  = rd_fire && m_tlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (overflow) begin
                wr_ptr <= commit_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                commit_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({commit, rd_last})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: ;
            endcase
            if (drop_last && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

`ifdef AXI_STR_RX_USER_EN
    assign wdata = {s_tdata, s_tkeep, s_tlast, s_tuser};
    assign {m_tdata, m_tkeep, m_tlast, m_tuser} = rdata;
`else
    logic unused_user;
    assign unused_user = ^s_tuser;
    assign wdata = {s_tdata, s_tkeep, s_tlast};
    assign {m_tdata, m_tkeep, m_tlast} = rdata;
    assign m_tuser = '0;
`endif

    axi_str_rx_mem #(
        .W     (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (aclk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_axi_str_rx_pkt_fifo.sv
// tb_axi_str_rx_pkt_fifo: directed self-checking bench, DEPTH=8.
module tb_axi_str_rx_pkt_fifo;

    localparam int DW = 32;
    localparam int UW = 32;
    localparam int DEPTH = 8;
    localparam int CW = 16;
    localparam int PCW = $clog2(DEPTH) + 1;

    logic            aclk = 1'b0;
    logic            areset;
    logic            s_tvalid, s_tready;
    logic [DW-1:0]   s_tdata;
    logic [DW/8-1:0] s_tkeep;
    logic            s_tlast;
    logic [UW-1:0]   s_tuser;
    logic            m_tvalid, m_tready;
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tkeep;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
    logic [PCW-1:0]  pkt_count;
    logic [CW-1:0]   drop_count;

    always #5 aclk = ~aclk;

    axi_str_rx_pkt_fifo #(
        .DATA_SIZE (DW),
        .USER_SIZE (UW),
        .DEPTH     (DEPTH),
        .CNT_W     (CW)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        sl;
        logic        mr;
        logic        exp_sr;
        logic        exp_mv;
        logic [31:0] exp_md;
        logic        exp_ml;
        logic [3:0]  exp_pc;
    } vec_t;

    vec_t tbl [7];
    int   checks = 0;
    int   failures = 0;
    logic mv_seen;
    int   st;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] base, input int n,
                        input bit close, output int stalls);
        int  i;
        int  cyc;
        logic rdy;
        i = 0;
        cyc = 0;
        stalls = 0;
        while (i < n && cyc < 50) begin
            s_tvalid = 1'b1;
            s_tdata  = base + 32'(i);
            s_tkeep  = 4'(i);
            s_tlast  = close && (i == n - 1);
            #1;
            if (m_tvalid) mv_seen = 1'b1;
            rdy = s_tready;
            tick();
            if (rdy) i++;
            else stalls++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("send_done", 64'(i), 64'(n));
    endtask

    initial begin
        // 3-beat packet, consumer always ready
        tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0};
        tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0};
        tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0};
        tbl[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 4'd1};
        tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 4'd1};
        tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 4'd1};
        tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0};

        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        m_tready = 1'b0;
        mv_seen  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        areset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            s_tvalid = tbl[i].sv;
            s_tdata  = tbl[i].sd;
            s_tlast  = tbl[i].sl;
            s_tkeep  = 4'hF;
            m_tready = tbl[i].mr;
            #1;
            chk($sformatf("t1_s_tready[%0d]", i), 64'(s_tready), 64'(tbl[i].exp_sr));
            chk($sformatf("t1_m_tvalid[%0d]", i), 64'(m_tvalid), 64'(tbl[i].exp_mv));
            chk($sformatf("t1_pkt_count[%0d]", i), 64'(pkt_count), 64'(tbl[i].exp_pc));
            if (tbl[i].exp_mv) begin
                chk($sformatf("t1_m_tdata[%0d]", i), 64'(m_tdata), 64'(tbl[i].exp_md));
                chk($sformatf("t1_m_tlast[%0d]", i), 64'(m_tlast), 64'(tbl[i].exp_ml));
                chk($sformatf("t1_m_tkeep[%0d]", i), 64'(m_tkeep), 64'hF);
            end
            tick();
        end

        // back-to-back single-beat packets, both sides ready
        for (int k = 0; k < 8; k++) begin
            s_tvalid = (k < 6);
            s_tdata  = 32'h100 + 32'(k);
            s_tlast  = 1'b1;
            #1;
            chk($sformatf("b2b_s_tready[%0d]", k), 64'(s_tready), 64'd1);
            if (k == 0 || k == 7) begin
                chk($sformatf("b2b_m_tvalid[%0d]", k), 64'(m_tvalid), 64'd0);
                chk($sformatf("b2b_pkt[%0d]", k), 64'(pkt_count), 64'd0);
            end else begin
                chk($sformatf("b2b_m_tvalid[%0d]", k), 64'(m_tvalid), 64'd1);
                chk($sformatf("b2b_m_tdata[%0d]", k), 64'(m_tdata), 64'(32'h100 + 32'(k - 1)));
                chk($sformatf("b2b_m_tlast[%0d]", k), 64'(m_tlast), 64'd1);
                chk($sformatf("b2b_pkt[%0d]", k), 64'(pkt_count), 64'd1);
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // fill with two 4-beat packets, then drain
        m_tready = 1'b0;
        send(32'h40, 4, 1'b1, st);
        chk("fill_stalls_a", 64'(st), 64'd0);
        send(32'h44, 4, 1'b1, st);
        chk("fill_stalls_b", 64'(st), 64'd0);
        #1;
        chk("fill_s_tready", 64'(s_tready), 64'd0);
        chk("fill_pkt_count", 64'(pkt_count), 64'd2);
        chk("fill_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("fill_hold_data", 64'(m_tdata), 64'h40);
        m_tready = 1'b1;
        #1;
        chk("fill_s_tready_same", 64'(s_tready), 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_m_tvalid[%0d]", k), 64'(m_tvalid), 64'd1);
            chk($sformatf("drain_m_tdata[%0d]", k), 64'(m_tdata), 64'(32'h40 + 32'(k)));
            chk($sformatf("drain_m_tlast[%0d]", k), 64'(m_tlast), 64'((k % 4) == 3));
            chk($sformatf("drain_m_tkeep[%0d]", k), 64'(m_tkeep), 64'(k % 4));
            if (k == 1) chk("drain_s_tready", 64'(s_tready), 64'd1);
            if (k == 4) chk("drain_pkt_mid", 64'(pkt_count), 64'd1);
            tick();
        end
        chk("drain_m_tvalid_end", 64'(m_tvalid), 64'd0);
        chk("drain_pkt_end", 64'(pkt_count), 64'd0);

        // oversize packet is dropped, next one passes
        m_tready = 1'b0;
        mv_seen  = 1'b0;
        send(32'h60, 10, 1'b1, st);
        chk("ovf_stalls", 64'(st), 64'd1);
        chk("ovf_drop_count", 64'(drop_count), 64'd1);
        chk("ovf_mv_seen", 64'(mv_seen), 64'd0);
        chk("ovf_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("ovf_pkt_count", 64'(pkt_count), 64'd0);
        send(32'h71, 2, 1'b1, st);
        #1;
        chk("post_pkt_count", 64'(pkt_count), 64'd1);
        m_tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("post_m_tvalid[%0d]", k), 64'(m_tvalid), 64'd1);
            chk($sformatf("post_m_tdata[%0d]", k), 64'(m_tdata), 64'(32'h71 + 32'(k)));
            chk($sformatf("post_m_tlast[%0d]", k), 64'(m_tlast), 64'(k == 1));
            tick();
        end
        chk("post_m_tvalid_end", 64'(m_tvalid), 64'd0);

        // tuser pass-through
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h9;
        s_tlast  = 1'b1;
        s_tuser  = 32'hA5A5_A5A5;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        #1;
        chk("user_m_tdata", 64'(m_tdata), 64'h9);
`ifdef AXI_STR_RX_USER_EN
        chk("user_m_tuser", 64'(m_tuser), 64'hA5A5_A5A5);
`else
        chk("user_m_tuser", 64'(m_tuser), 64'h0);
`endif
        m_tready = 1'b1;
        tick();
        chk("user_m_tvalid_end", 64'(m_tvalid), 64'd0);

        // reset with a committed packet and a partial one in flight
        m_tready = 1'b0;
        send(32'h81, 1, 1'b1, st);
        send(32'h82, 2, 1'b0, st);
        #1;
        chk("pre_rst_pkt", 64'(pkt_count), 64'd1);
        chk("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
        s_tvalid = 1'b1;
        s_tdata  = 32'h84;
        areset   = 1'b1;
        #1;
        chk("in_rst_s_tready", 64'(s_tready), 64'd0);
        chk("in_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        tick();
        chk("rst2_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst2_drop_count", 64'(drop_count), 64'd0);
        chk("rst2_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst2_s_tready", 64'(s_tready), 64'd0);
        areset   = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("post_rst_s_tready", 64'(s_tready), 64'd1);
        chk("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        tick();
        chk("post_rst_m_tvalid2", 64'(m_tvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
